// File: rtl/dest_ack_handshake.sv
// Destination-side four-phase req/ack responder: synchronises the source request,
// captures the source word, hands it to a local valid/ready consumer and returns ack.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for synchronised req to rise; ack low, nothing held
// VALID | word captured and offered to the consumer; waiting for ready
// ACK   | word accepted, ack high; waiting for req to fall before re-arming
module dest_ack_handshake #(
    parameter int DATAWIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNTWIDTH    = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 src2dest_req,
    input  logic [DATAWIDTH-1:0] src2dest_data,
    output logic [DATAWIDTH-1:0] dest_data_out,
    output logic                 dest_data_valid,
    input  logic                 dest_data_ready,
    output logic                 dest2src_ack,
    output logic [CNTWIDTH-1:0]  dest_xfer_count,
    output logic                 dest_proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    logic [DATAWIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ack_q, ack_d;
    logic [CNTWIDTH-1:0]    count_q, count_d;
    logic                   err_q, err_d;

    // Only the last synchroniser stage is ever looked at by the FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src2dest_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        count_d = count_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    data_d  = src2dest_data;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // A dropped request is flagged, but the held word is still delivered.
                if (!req_s) begin
                    err_d = 1'b1;
                end
                if (dest_data_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    count_d = count_q + CNTWIDTH'(1);
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dest_data_out   = data_q;
    assign dest_data_valid = valid_q;
    assign dest2src_ack    = ack_q;
    assign dest_xfer_count = count_q;
    assign dest_proto_err  = err_q;

endmodule

// File: doc/dest_ack_handshake.md
# dest_ack_handshake

Destination-side responder for the four-phase req/ack crossing between the source and destination clock domains. It synchronises the source request level into its own clock and captures the source data word. It presents the word to a local consumer with a valid/ready handshake and returns an acknowledge level to the source, so destination backpressure reaches the sender. It sits in the destination clock domain as the return-path partner of the source-side transmitter, complementing the one-way load-pulse path.

## Interface
- DATAWIDTH, 8, width of the transferred data word
- SYNC_STAGES, 2, flops in the request synchroniser chain; legal range 2..4
- CNTWIDTH, 8, width of the completed-transfer counter
- CLK  input  1  destination-domain clock; all state in this block is clocked on its rising edge
- RST  input  1  asynchronous, active-high reset; clears all state immediately
- src2dest_req  input  1  request level from the source domain; asynchronous to CLK
- src2dest_data  input  DATAWIDTH  source data; the source holds it stable from req rise until ack rise
- dest_data_out  output  DATAWIDTH  captured word, stable while dest_data_valid is high
- dest_data_valid  output  1  captured word available to the consumer
- dest_data_ready  input  1  consumer accepts the word on a cycle where valid and ready are both high
- dest2src_ack  output  1  acknowledge level to the source domain, driven directly from a flop
- dest_xfer_count  output  CNTWIDTH  number of accepted words; wraps modulo 2^CNTWIDTH
- dest_proto_err  output  1  sticky flag: request dropped before the word was accepted

## Operation
- Synchroniser: src2dest_req passes through SYNC_STAGES flops, all reset to 0. req_s is the last stage. Only req_s is used by the FSM.
- FSM states are IDLE, VALID and ACK. Reset state is IDLE.
- IDLE, req_s=1:
  - dest_data_out <= src2dest_data
  - dest_data_valid <= 1
  - go to VALID
- IDLE, req_s=0: hold.
- VALID, dest_data_ready=1:
  - dest_data_valid <= 0
  - dest2src_ack <= 1
  - dest_xfer_count increments
  - go to ACK
- VALID, dest_data_ready=0: hold. dest_data_out and valid are unchanged.
- VALID, req_s=0: set dest_proto_err <= 1 and stay in VALID; the word is still delivered. If ready is also high in the same cycle, the accept proceeds normally.
- ACK, req_s=0: dest2src_ack <= 0, go to IDLE.
- ACK, req_s=1: hold with ack high.
- dest_data_ready is ignored outside VALID.
- Counter wraps from 2^CNTWIDTH-1 to 0 with no flag.
- dest_proto_err clears only on RST.
- Reset values: dest_data_out=0, dest_data_valid=0, dest2src_ack=0, dest_xfer_count=0, dest_proto_err=0, synchroniser=0.
- Reset mid-operation: any word in flight is discarded and ack drops at once. If the source still holds req high after RST releases, the word is captured again after SYNC_STAGES+1 edges. The source domain shares the reset so this does not occur in normal use.

## Timing
- Edge numbering: req rises before edge 1. With SYNC_STAGES=S, req_s=1 after edge S, and dest_data_valid=1 after edge S+1, ignoring a metastability extension of at most one cycle.
- Accept: valid falls, ack rises and the count updates on the same edge where valid&ready was sampled. When ready is already high, valid is high for exactly one cycle.
- Release: ack falls S+1 edges after req falls.
- No new capture is possible until ack has fallen and req_s has risen again, so no word is captured twice.
- Minimum full handshake seen from CLK, with ready held high: 2S+3 cycles plus the source-side round trip.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Basic transfer, S=2, ready held high: set data=0xA5, raise req -> valid high for one cycle after edge 3 with dest_data_out=0xA5, ack high from edge 4, count=1. Drop req -> ack low 3 edges later.
- Backpressure: ready low for 10 cycles after valid rises, data=0x3C -> valid and 0x3C held for 10 cycles, ack stays 0. Raise ready -> ack rises on the next edge.
- Back-to-back: 300 transfers with random data and random ready gaps -> every word delivered in order, no duplicates, count wraps to 44 (300 mod 256), dest_proto_err=0.
- Protocol violation: drop req while in VALID -> dest_proto_err=1 and the word is still delivered. After accept, ack releases, and dest_proto_err stays 1 until RST.
- Reset mid-operation: assert RST in the ACK state -> ack, valid and count go to 0 asynchronously. Keep req high through RST release -> the word is captured again after S+1 edges.
